// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter between the MEM stage and the SPI loader.
// Optional round-robin arbitration is enabled with DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_SPI
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE,
    S_SPI
  } state_e;

  localparam int unsigned LOCK_MAX_DEF = 8;
  localparam int unsigned LOCK_CW = $clog2(LOCK_MAX_DEF + 1);

  function automatic int unsigned cnt_w(input int unsigned lmax);
    return $clog2(lmax + 1);
  endfunction

endpackage

// File: rtl/dmem_rsp_route.sv
// One-deep read response register: remembers who issued the last read
// and steers the memory's 1-cycle-late data back to that requester.
module dmem_rsp_route
  import dmem_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_core_i,
  input  logic          rd_spi_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          core_rvalid_o,
  output logic          spi_rvalid_o,
  output logic [DW-1:0] rdata_o
);

  owner_e        pend_q;
  owner_e        pend_d;
  logic [DW-1:0] rdata_q;

  always_comb begin
    pend_d = OWN_NONE;
    unique case (1'b1)
      rd_core_i: pend_d = OWN_CORE;
      rd_spi_i:  pend_d = OWN_SPI;
      default:   pend_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= OWN_NONE;
      rdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (pend_q != OWN_NONE) rdata_q <= mem_rdata_i;
    end
  end

  assign core_rvalid_o = (pend_q == OWN_CORE);
  assign spi_rvalid_o  = (pend_q == OWN_SPI);
  // Live memory data on the response cycle, held copy otherwise.
  assign rdata_o = (pend_q != OWN_NONE) ? mem_rdata_i : rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core MEM stage vs SPI loader, with SPI burst lock.
// Define DMEM_ARB_RR_EN for round-robin on unlocked contested cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_ready,
  output logic          core_stall,
  output logic          core_rvalid,
  input  logic          spi_req,
  input  logic          spi_lock,
  input  logic          spi_we,
  input  logic [AW-1:0] spi_addr,
  input  logic [DW-1:0] spi_wdata,
  output logic          spi_ready,
  output logic          spi_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = cnt_w(LOCK_MAX);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lock_act;
  logic          rr_spi;
  logic          spi_pick;
  logic          core_gnt;
  logic          spi_gnt;

`ifdef DMEM_ARB_RR_EN
  owner_e        last_q;
  owner_e        last_d;

  assign rr_spi = (last_q == OWN_CORE);

  always_comb begin
    last_d = last_q;
    if (core_gnt) last_d = OWN_CORE;
    else if (spi_gnt) last_d = OWN_SPI;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= OWN_CORE;
    else      last_q <= last_d;
  end
`else
  assign rr_spi = 1'b0;
`endif

  assign lock_act = (state_q == S_SPI) & spi_lock
                  & (cnt_q < CW'(LOCK_MAX));
  assign spi_pick = core_req & spi_req & (lock_act | rr_spi);
  assign core_gnt = rst & core_req & ~spi_pick;
  assign spi_gnt  = rst & spi_req & ~core_gnt;

  assign core_ready = core_gnt;
  assign spi_ready  = spi_gnt;
  assign core_stall = rst & core_req & ~core_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      core_gnt: begin
        mem_en    = 1'b1;
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      spi_gnt: begin
        mem_en    = 1'b1;
        mem_we    = spi_we;
        mem_addr  = spi_addr;
        mem_wdata = spi_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = S_IDLE;
    if (core_gnt) state_d = S_CORE;
    else if (spi_gnt) state_d = S_SPI;
  end

  // Only contested beats inside an SPI run consume the lock budget.
  always_comb begin
    cnt_d = cnt_q;
    if (core_gnt || !spi_lock)
      cnt_d = '0;
    else if (spi_gnt && core_req && state_q == S_SPI)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  dmem_rsp_route #(.DW(DW)) u_rsp (
    .clk          (clk),
    .rst_n        (rst),
    .rd_core_i    (core_gnt & ~core_we),
    .rd_spi_i     (spi_gnt & ~spi_we),
    .mem_rdata_i  (mem_rdata),
    .core_rvalid_o(core_rvalid),
    .spi_rvalid_o (spi_rvalid),
    .rdata_o      (rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LOCK_MAX = 8;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_ready;
  logic          core_stall;
  logic          core_rvalid;
  logic          spi_req = 1'b0;
  logic          spi_lock = 1'b0;
  logic          spi_we = 1'b0;
  logic [AW-1:0] spi_addr = '0;
  logic [DW-1:0] spi_wdata = '0;
  logic          spi_ready;
  logic          spi_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ready (core_ready),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .spi_req    (spi_req),
    .spi_lock   (spi_lock),
    .spi_we     (spi_we),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_ready  (spi_ready),
    .spi_rvalid (spi_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Environment memory: synchronous single port, 32 words.
  logic [DW-1:0] env_mem [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[6:2]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[6:2]];
    end
  end

  // Model: 0 = none, 1 = core, 2 = spi
  int            m_owner;
  int            m_burst;
  int            m_last;
  int            m_rsp;
  logic [31:0]   m_rval;
  logic [31:0]   m_hold;
  logic [31:0]   m_mem [32];

  int            vectors = 0;
  int            miscompares = 0;
  bit            obs_cr;
  bit            obs_sr;
  bit            obs_stall;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_burst = 0;
    m_last  = 1;
    m_rsp   = 0;
    m_rval  = '0;
    m_hold  = '0;
  endtask

  // Check one cycle against the model, then step the model and move to the next negedge.
  task automatic cycle();
    int          w;
    bit          locked;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    #1;
    locked = (m_owner == 2) && spi_lock && (m_burst < LOCK_MAX);
    if (core_req && spi_req) begin
      if (locked)  w = 2;
      else if (RR) w = (m_last == 1) ? 2 : 1;
      else         w = 1;
    end else if (core_req) w = 1;
    else if (spi_req)      w = 2;
    else                   w = 0;
    a  = (w == 1) ? core_addr  : (w == 2) ? spi_addr  : 32'h0;
    d  = (w == 1) ? core_wdata : (w == 2) ? spi_wdata : 32'h0;
    we = (w == 1) ? core_we    : (w == 2) ? spi_we    : 1'b0;
    chk("core_ready", 32'(core_ready), 32'(w == 1));
    chk("spi_ready", 32'(spi_ready), 32'(w == 2));
    chk("core_stall", 32'(core_stall), 32'(core_req && w != 1));
    chk("mem_en", 32'(mem_en), 32'(w != 0));
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    chk("core_rvalid", 32'(core_rvalid), 32'(m_rsp == 1));
    chk("spi_rvalid", 32'(spi_rvalid), 32'(m_rsp == 2));
    chk("rdata", rdata, (m_rsp != 0) ? m_rval : m_hold);
    obs_cr    = core_ready;
    obs_sr    = spi_ready;
    obs_stall = core_stall;
    if (m_rsp != 0) m_hold = m_rval;
    m_rsp = 0;
    if (w != 0) begin
      if (we) m_mem[a[6:2]] = d;
      else begin
        m_rsp  = w;
        m_rval = m_mem[a[6:2]];
      end
      m_last = w;
    end
    if (w == 1 || !spi_lock) m_burst = 0;
    else if (w == 2 && core_req && m_owner == 2) m_burst++;
    m_owner = w;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    core_req = 1'b0;
    spi_req  = 1'b0;
    spi_lock = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] raddr();
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int beats;
    int stalls;
    bit done;
    for (int i = 0; i < 32; i++) begin
      env_mem[i] = '0;
      m_mem[i]   = '0;
    end
    model_reset();

    // Reset forces everything low, even with a request present
    @(negedge clk);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'h10;
    #1;
    chk("rst_core_ready", 32'(core_ready), 32'h0);
    chk("rst_stall", 32'(core_stall), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // Read accepted, then reset before the response
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_accept", 32'(core_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rvalid", 32'(core_rvalid), 32'h0);
    chk("mid_mem_en", 32'(mem_en), 32'h0);
    @(negedge clk);
    core_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk("post_rst_rvalid", 32'(core_rvalid), 32'h0);
    cycle();

    // Contention without lock
    reset_dut();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    spi_req  = 1'b1; spi_we  = 1'b0; spi_addr  = 32'h10;
    cycle();
    chk("cont_core_first", 32'(obs_cr), 32'(!RR));
    chk("cont_spi_wait", 32'(obs_sr), 32'(RR));
    chk("cont_stall", 32'(obs_stall), 32'(RR));
    if (obs_cr) core_req = 1'b0;
    else        spi_req  = 1'b0;
    cycle();
    chk("cont_second", 32'(RR ? obs_cr : obs_sr), 32'h1);
    chk("cont_stall2", 32'(obs_stall), 32'h0);
    core_req = 1'b0;
    spi_req  = 1'b0;
    cycle();

    // Locked SPI burst against a waiting core
    reset_dut();
    spi_req = 1'b1; spi_lock = 1'b1; spi_we = 1'b1;
    spi_addr = raddr(); spi_wdata = $urandom;
    cycle();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8;
    beats = 0; stalls = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      spi_addr  = raddr();
      spi_wdata = $urandom;
      cycle();
      beats  += int'(obs_sr);
      stalls += int'(obs_stall);
      if (obs_cr) done = 1'b1;
    end
    chk("lock_done", 32'(done), 32'h1);
    chk("lock_beats", 32'(beats), 32'd8);
    chk("lock_stalls", 32'(stalls), 32'd8);
    chk("lock_cnt_clr", 32'(dut.cnt_q), 32'h0);
    core_req = 1'b0; spi_req = 1'b0; spi_lock = 1'b0;
    cycle();

    // Read latency and owner routing
    reset_dut();
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 32'h20; spi_wdata = 32'hDEADBEEF;
    cycle();
    spi_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
    cycle();
    core_req = 1'b0;
    chk("lat_rvalid", 32'(core_rvalid), 32'h1);
    chk("lat_rdata", rdata, 32'hDEADBEEF);
    cycle();
    chk("lat_one_pulse", 32'(core_rvalid), 32'h0);
    chk("lat_hold", rdata, 32'hDEADBEEF);
    core_req = 1'b1;
    cycle();
    core_req = 1'b0;
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 32'h20;
    cycle();
    spi_req = 1'b0;
    chk("alt_spi_rvalid", 32'(spi_rvalid), 32'h1);
    chk("alt_core_quiet", 32'(core_rvalid), 32'h0);
    cycle();

    // Write then immediate read
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 32'h40; spi_wdata = 32'hA5A5A5A5;
    cycle();
    spi_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    cycle();
    core_req = 1'b0;
    chk("wr_rd_rvalid", 32'(core_rvalid), 32'h1);
    chk("wr_rd_data", rdata, 32'hA5A5A5A5);
    cycle();

    // Continuous contention, no lock
    reset_dut();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h4;
    spi_req  = 1'b1; spi_we  = 1'b0; spi_addr  = 32'h8;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk($sformatf("fair_%0d", i), 32'(obs_cr),
          32'(RR ? (i % 2 == 1) : 1'b1));
    end
    core_req = 1'b0;
    spi_req  = 1'b0;
    cycle();

    // Randomized traffic honouring the hold-until-ready rule
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (!(core_req && !obs_cr)) begin
        core_req   = ($urandom_range(0, 2) != 0);
        core_we    = $urandom_range(0, 1) == 1;
        core_addr  = raddr();
        core_wdata = $urandom;
      end
      if (!(spi_req && !obs_sr)) begin
        spi_req   = ($urandom_range(0, 2) != 0);
        spi_lock  = ($urandom_range(0, 3) != 0);
        spi_we    = $urandom_range(0, 1) == 1;
        spi_addr  = raddr();
        spi_wdata = $urandom;
      end
    end
    core_req = 1'b0;
    spi_req  = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
